// File: rtl/conv_tile_serializer.sv
// conv_tile_serializer
// Holds N_CH-tile beats from the IFFT bank in a small FIFO and streams each
// buffered beat out as N_CH cachelines, one tile per transfer.
// Optional ReLU is applied as a beat is written. A sticky flag records beats
// that were dropped because the FIFO was full.

module conv_tile_serializer #(
  parameter int N_CH  = 4,
  parameter int TILE  = 16,
  parameter int DW    = 32,
  parameter int DEPTH = 4,
  localparam int BEAT_W = N_CH * TILE * DW,
  localparam int LINE_W = TILE * DW,
  localparam int CH_W   = (N_CH > 1) ? $clog2(N_CH) : 1,
  localparam int CNT_W  = $clog2(DEPTH + 1)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              relu_en,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [BEAT_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [LINE_W-1:0] out_data,
  output logic [CH_W-1:0]   out_ch,
  output logic              out_last,
  output logic [CNT_W-1:0]  count,
  output logic              overflow,
  input  logic              ovf_clr
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  typedef enum logic {
    EMPTY  = 1'b0,
    STREAM = 1'b1
  } state_t;

  state_t            state_q;
  state_t            state_d;
  logic [BEAT_W-1:0] mem [DEPTH];
  logic [BEAT_W-1:0] relu_beat;
  logic [BEAT_W-1:0] head_beat;
  logic [PTR_W-1:0]  wr_ptr;
  logic [PTR_W-1:0]  rd_ptr;
  logic [CH_W-1:0]   ch_cnt;
  logic [CNT_W-1:0]  count_q;
  logic              wr_en;
  logic              xfer;
  logic              pop;
  logic              last_ch;

  // Pointers step through 0..DEPTH-1; DEPTH need not be a power of two.
  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  // A full FIFO refuses the beat even when a pop lands in the same cycle.
  assign in_ready  = (count_q != CNT_W'(DEPTH));
  assign out_valid = (state_q == STREAM);
  assign wr_en     = in_valid && in_ready;
  assign last_ch   = (ch_cnt == CH_W'(N_CH - 1));
  assign xfer      = out_valid && out_ready;
  assign pop       = xfer && last_ch;

  assign head_beat = mem[rd_ptr];
  assign out_data  = head_beat[int'(ch_cnt) * LINE_W +: LINE_W];
  assign out_ch    = ch_cnt;
  assign out_last  = last_ch;
  assign count     = count_q;

  // ReLU on the write path: any element with its sign bit set becomes +0.0.
  always_comb begin
    relu_beat = in_data;
    for (int i = 0; i < N_CH * TILE; i++) begin
      if (relu_en && in_data[i*DW + DW - 1]) begin
        relu_beat[i*DW +: DW] = '0;
      end
    end
  end

  // Beat storage, deliberately left out of reset.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_ptr] <= relu_beat;
    end
  end

  // FSM next state: STREAM whenever at least one entry is held.
  always_comb begin
    state_d = state_q;
    case (state_q)
      EMPTY:   if (wr_en) state_d = STREAM;
      STREAM:  if (pop && !wr_en && (count_q == CNT_W'(1))) state_d = EMPTY;
      default: state_d = EMPTY;
    endcase
  end

  // FSM state register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= EMPTY;
    end else begin
      state_q <= state_d;
    end
  end

  // Write pointer, read pointer, channel counter and occupancy.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      ch_cnt  <= '0;
      count_q <= '0;
    end else begin
      if (wr_en) begin
        wr_ptr <= ptr_inc(wr_ptr);
      end
      if (xfer) begin
        if (last_ch) begin
          ch_cnt <= '0;
          rd_ptr <= ptr_inc(rd_ptr);
        end else begin
          ch_cnt <= ch_cnt + 1'b1;
        end
      end
      if (wr_en && !pop) begin
        count_q <= count_q + 1'b1;
      end else if (pop && !wr_en) begin
        count_q <= count_q - 1'b1;
      end
    end
  end

  // Sticky overflow; a drop in the same cycle as a clear keeps it set.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      overflow <= 1'b0;
    end else if (in_valid && !in_ready) begin
      overflow <= 1'b1;
    end else if (ovf_clr) begin
      overflow <= 1'b0;
    end
  end

endmodule

// File: tb/tb_conv_tile_serializer.sv
// tb_conv_tile_serializer
// Directed bench for conv_tile_serializer with a queue-based reference model
// that is compared against the DUT on every falling clock edge.

module tb_conv_tile_serializer;

  localparam int N_CH   = 4;
  localparam int TILE   = 16;
  localparam int DW     = 32;
  localparam int DEPTH  = 4;
  localparam int BEAT_W = N_CH * TILE * DW;
  localparam int LINE_W = TILE * DW;
  localparam int CH_W   = 2;
  localparam int CNT_W  = 3;

  logic              clk;
  logic              rst_n;
  logic              relu_en;
  logic              in_valid;
  logic              in_ready;
  logic [BEAT_W-1:0] in_data;
  logic              out_valid;
  logic              out_ready;
  logic [LINE_W-1:0] out_data;
  logic [CH_W-1:0]   out_ch;
  logic              out_last;
  logic [CNT_W-1:0]  count;
  logic              overflow;
  logic              ovf_clr;

  int checks;
  int failures;
  int xfer_count;

  logic [BEAT_W-1:0] model_q[$];
  int                model_ch;
  logic              model_ovf;
  int                size_before;
  logic [BEAT_W-1:0] head;

  conv_tile_serializer #(
    .N_CH (N_CH),
    .TILE (TILE),
    .DW   (DW),
    .DEPTH(DEPTH)
  ) dut (
    .clk      (clk),
    .reset    (rst_n),
    .relu_en  (relu_en),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_data  (in_data),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_data (out_data),
    .out_ch   (out_ch),
    .out_last (out_last),
    .count    (count),
    .overflow (overflow),
    .ovf_clr  (ovf_clr)
  );

  // Free-running clock.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Beat whose element k of channel c holds base + c*16 + k.
  function automatic logic [BEAT_W-1:0] make_beat(input logic [31:0] base);
    logic [BEAT_W-1:0] b;
    b = '0;
    for (int c = 0; c < N_CH; c++) begin
      for (int k = 0; k < TILE; k++) begin
        b[(c*TILE + k)*DW +: DW] = base + 32'(c * 16 + k);
      end
    end
    return b;
  endfunction

  // Expected cacheline for channel c of make_beat(base).
  function automatic logic [LINE_W-1:0] make_line(input logic [31:0] base, input int c);
    logic [LINE_W-1:0] l;
    for (int k = 0; k < TILE; k++) begin
      l[k*DW +: DW] = base + 32'(c * 16 + k);
    end
    return l;
  endfunction

  // Element k of a cacheline.
  function automatic logic [31:0] elem(input logic [LINE_W-1:0] l, input int k);
    return l[k*DW +: DW];
  endfunction

  // Reference ReLU: negative values and -0.0 become +0.0 when enabled.
  function automatic logic [BEAT_W-1:0] model_relu(input logic [BEAT_W-1:0] b, input logic en);
    logic [BEAT_W-1:0] r;
    logic [31:0]       e;
    r = b;
    for (int i = 0; i < N_CH * TILE; i++) begin
      e = b[i*DW +: DW];
      if (en && e[31]) r[i*DW +: DW] = 32'h0;
    end
    return r;
  endfunction

  task automatic checkOutput(input string name, input logic [LINE_W-1:0] actual,
                             input logic [LINE_W-1:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s: got %0h expected %0h", name, actual, expected);
    end
  endtask

  // Drive one cycle of inputs, let one rising edge consume them, return 1 ns after it.
  task automatic applyStimulus(input logic v, input logic [BEAT_W-1:0] d, input logic relu,
                               input logic ordy, input logic clr);
    in_valid  = v;
    in_data   = d;
    relu_en   = relu;
    out_ready = ordy;
    ovf_clr   = clr;
    @(posedge clk);
    #1;
  endtask

  // Reference model: a queue of stored beats plus the channel being drained.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      model_q.delete();
      model_ch  = 0;
      model_ovf = 1'b0;
    end else begin
      size_before = model_q.size();
      if (size_before > 0 && out_ready) begin
        if (model_ch == N_CH - 1) begin
          model_ch = 0;
          void'(model_q.pop_front());
        end else begin
          model_ch = model_ch + 1;
        end
      end
      if (in_valid && size_before < DEPTH) begin
        model_q.push_back(model_relu(in_data, relu_en));
      end
      if (in_valid && size_before >= DEPTH) model_ovf = 1'b1;
      else if (ovf_clr)                     model_ovf = 1'b0;
    end
  end

  // Compare the DUT against the model on every falling edge.
  always @(negedge clk) begin
    checkOutput("m_out_valid", LINE_W'(out_valid), LINE_W'(model_q.size() != 0));
    checkOutput("m_in_ready", LINE_W'(in_ready), LINE_W'(model_q.size() != DEPTH));
    checkOutput("m_count", LINE_W'(count), LINE_W'(model_q.size()));
    checkOutput("m_overflow", LINE_W'(overflow), LINE_W'(model_ovf));
    if (model_q.size() != 0) begin
      head = model_q[0];
      checkOutput("m_out_ch", LINE_W'(out_ch), LINE_W'(model_ch));
      checkOutput("m_out_last", LINE_W'(out_last), LINE_W'(model_ch == N_CH - 1));
      checkOutput("m_out_data", out_data, head[model_ch*LINE_W +: LINE_W]);
    end
    if (rst_n && out_valid && out_ready) xfer_count++;
  end

  logic [BEAT_W-1:0] relu_beat;
  logic [31:0]       bases [4];

  initial begin
    checks     = 0;
    failures   = 0;
    xfer_count = 0;
    rst_n      = 1'b0;
    relu_en    = 1'b0;
    in_valid   = 1'b0;
    in_data    = '0;
    out_ready  = 1'b0;
    ovf_clr    = 1'b0;

    // Reset held for three cycles.
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;
    #1;
    checkOutput("rst_out_valid", LINE_W'(out_valid), '0);
    checkOutput("rst_in_ready", LINE_W'(in_ready), LINE_W'(1));
    checkOutput("rst_count", LINE_W'(count), '0);
    checkOutput("rst_overflow", LINE_W'(overflow), '0);
    applyStimulus(0, '0, 0, 0, 0);

    // Single beat drained with out_ready held high.
    $display("[TB] single beat");
    applyStimulus(1, make_beat(32'h0), 0, 1, 0);
    for (int c = 0; c < N_CH; c++) begin
      checkOutput("t2_out_ch", LINE_W'(out_ch), LINE_W'(c));
      checkOutput("t2_out_last", LINE_W'(out_last), LINE_W'(c == 3));
      checkOutput("t2_elem5", LINE_W'(elem(out_data, 5)), LINE_W'(c * 16 + 5));
      checkOutput("t2_line", out_data, make_line(32'h0, c));
      applyStimulus(0, '0, 0, 1, 0);
    end
    checkOutput("t2_count_end", LINE_W'(count), '0);

    // Backpressure for five cycles while sitting on channel 2.
    $display("[TB] backpressure");
    applyStimulus(1, make_beat(32'h1000), 0, 0, 0);
    applyStimulus(0, '0, 0, 1, 0);
    applyStimulus(0, '0, 0, 1, 0);
    for (int i = 0; i < 5; i++) begin
      checkOutput("t3_stall_ch", LINE_W'(out_ch), LINE_W'(2));
      checkOutput("t3_stall_data", out_data, make_line(32'h1000, 2));
      applyStimulus(0, '0, 0, 0, 0);
    end
    checkOutput("t3_resume_ch", LINE_W'(out_ch), LINE_W'(2));
    applyStimulus(0, '0, 0, 1, 0);
    checkOutput("t3_next_ch", LINE_W'(out_ch), LINE_W'(3));
    applyStimulus(0, '0, 0, 1, 0);
    checkOutput("t3_count_end", LINE_W'(count), '0);

    // Fill to capacity, then overflow with a simultaneous clear request.
    $display("[TB] fill and overflow");
    bases = '{32'h100, 32'h200, 32'h300, 32'h400};
    for (int b = 0; b < 4; b++) applyStimulus(1, make_beat(bases[b]), 0, 0, 0);
    checkOutput("t4_full_count", LINE_W'(count), LINE_W'(4));
    checkOutput("t4_full_ready", LINE_W'(in_ready), '0);
    applyStimulus(1, make_beat(32'h900), 0, 0, 1);
    checkOutput("t4_ovf_set", LINE_W'(overflow), LINE_W'(1));
    checkOutput("t4_ovf_count", LINE_W'(count), LINE_W'(4));
    for (int b = 0; b < 4; b++) begin
      for (int c = 0; c < N_CH; c++) begin
        checkOutput("t4_drain_ch", LINE_W'(out_ch), LINE_W'(c));
        checkOutput("t4_drain_elem0", LINE_W'(elem(out_data, 0)), LINE_W'(bases[b] + 32'(c * 16)));
        applyStimulus(0, '0, 0, 1, 0);
      end
    end
    checkOutput("t4_empty_count", LINE_W'(count), '0);
    checkOutput("t4_ovf_sticky", LINE_W'(overflow), LINE_W'(1));
    applyStimulus(0, '0, 0, 0, 1);
    checkOutput("t4_ovf_clr", LINE_W'(overflow), '0);

    // Ten beats, one every four cycles, draining continuously through pointer wrap.
    $display("[TB] wrap and simultaneous write/pop");
    xfer_count = 0;
    for (int i = 0; i < 10; i++) begin
      applyStimulus(1, make_beat(32'h2000 + 32'(i * 256)), 0, 1, 0);
      checkOutput("t5_count_one", LINE_W'(count), LINE_W'(1));
      checkOutput("t5_first_line", out_data, make_line(32'h2000 + 32'(i * 256), 0));
      for (int j = 0; j < 3; j++) applyStimulus(0, '0, 0, 1, 0);
    end
    applyStimulus(0, '0, 0, 1, 0);
    checkOutput("t5_xfers", LINE_W'(xfer_count), LINE_W'(40));
    checkOutput("t5_count_end", LINE_W'(count), '0);
    checkOutput("t5_no_ovf", LINE_W'(overflow), '0);

    // ReLU on and off.
    $display("[TB] relu");
    relu_beat = make_beat(32'h7);
    relu_beat[0*DW +: DW] = 32'hBFC00000;
    relu_beat[1*DW +: DW] = 32'h80000000;
    relu_beat[2*DW +: DW] = 32'h40000000;
    applyStimulus(1, relu_beat, 1, 0, 0);
    checkOutput("t6_relu_neg", LINE_W'(elem(out_data, 0)), '0);
    checkOutput("t6_relu_negzero", LINE_W'(elem(out_data, 1)), '0);
    checkOutput("t6_relu_pos", LINE_W'(elem(out_data, 2)), LINE_W'(32'h40000000));
    for (int c = 0; c < N_CH; c++) applyStimulus(0, '0, 0, 1, 0);
    applyStimulus(1, relu_beat, 0, 0, 0);
    checkOutput("t6_pass_neg", LINE_W'(elem(out_data, 0)), LINE_W'(32'hBFC00000));
    checkOutput("t6_pass_negzero", LINE_W'(elem(out_data, 1)), LINE_W'(32'h80000000));
    checkOutput("t6_pass_pos", LINE_W'(elem(out_data, 2)), LINE_W'(32'h40000000));
    for (int c = 0; c < N_CH; c++) applyStimulus(0, '0, 0, 1, 0);

    // Reset in the middle of a drain.
    $display("[TB] reset mid-drain");
    applyStimulus(1, make_beat(32'h3000), 0, 1, 0);
    applyStimulus(0, '0, 0, 1, 0);
    checkOutput("t7_pre_ch", LINE_W'(out_ch), LINE_W'(1));
    rst_n = 1'b0;
    #1;
    checkOutput("t7_async_valid", LINE_W'(out_valid), '0);
    checkOutput("t7_async_ready", LINE_W'(in_ready), LINE_W'(1));
    checkOutput("t7_async_ch", LINE_W'(out_ch), '0);
    applyStimulus(0, '0, 0, 1, 0);
    applyStimulus(0, '0, 0, 1, 0);
    rst_n = 1'b1;
    applyStimulus(0, '0, 0, 1, 0);
    checkOutput("t7_post_count", LINE_W'(count), '0);
    checkOutput("t7_post_valid", LINE_W'(out_valid), '0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
